// File: rtl/aes_pkg.sv
// Shared AES widths, state byte-indexing helpers and GF(2^8) arithmetic
// (polynomial 0x11B) used by the round back-end and its MixColumns columns.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NB      = 4;

    // Byte k of the state holds (row, col) with k = 4*col + row, MSB first.
    function automatic int byte_idx(input int row, input int col);
        return AES_NB * col + row;
    endfunction

    function automatic int byte_msb(input int row, input int col);
        return AES_STATE_W - 1 - AES_BYTE_W * byte_idx(row, col);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_column.sv
// One-column MixColumns (32 bits, row 0 in the top byte), purely combinational.
// The InvMixColumns path and the inv_i port exist only when SMA_INV_EN is defined.
module mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
`ifdef SMA_INV_EN
    input  logic        inv_i,
`endif
    output logic [31:0] col_o
);

    logic [7:0] b0, b1, b2, b3;
    logic [7:0] e0, e1, e2, e3;

    assign b0 = col_i[31:24];
    assign b1 = col_i[23:16];
    assign b2 = col_i[15:8];
    assign b3 = col_i[7:0];

    assign e0 = gmul(b0, 8'h02) ^ gmul(b1, 8'h03) ^ b2 ^ b3;
    assign e1 = b0 ^ gmul(b1, 8'h02) ^ gmul(b2, 8'h03) ^ b3;
    assign e2 = b0 ^ b1 ^ gmul(b2, 8'h02) ^ gmul(b3, 8'h03);
    assign e3 = gmul(b0, 8'h03) ^ b1 ^ b2 ^ gmul(b3, 8'h02);

`ifdef SMA_INV_EN
    logic [7:0] d0, d1, d2, d3;

    assign d0 = gmul(b0, 8'h0e) ^ gmul(b1, 8'h0b) ^ gmul(b2, 8'h0d) ^ gmul(b3, 8'h09);
    assign d1 = gmul(b0, 8'h09) ^ gmul(b1, 8'h0e) ^ gmul(b2, 8'h0b) ^ gmul(b3, 8'h0d);
    assign d2 = gmul(b0, 8'h0d) ^ gmul(b1, 8'h09) ^ gmul(b2, 8'h0e) ^ gmul(b3, 8'h0b);
    assign d3 = gmul(b0, 8'h0b) ^ gmul(b1, 8'h0d) ^ gmul(b2, 8'h09) ^ gmul(b3, 8'h0e);

    assign col_o = inv_i ? {d0, d1, d2, d3} : {e0, e1, e2, e3};
`else
    assign col_o = {e0, e1, e2, e3};
`endif

endmodule

// File: rtl/shift_mix_ark.sv
// AES round back-end: ShiftRows -> MixColumns (skipped on the last round) -> AddRoundKey,
// as a 2-stage valid/ready pipeline. SMA_INV_EN adds in_inv for the equivalent-inverse round.
module shift_mix_ark
    import aes_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic [AES_STATE_W-1:0] in_key,
    input  logic                   in_last,
    input  logic [TAG_W-1:0]       in_tag,
`ifdef SMA_INV_EN
    input  logic                   in_inv,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic [TAG_W-1:0]       out_tag
);

    // Handshake: a beat moves on any edge where valid && ready; valid never depends on
    // ready, each stage advances when it is empty or the stage after it advances, and
    // in_ready is the combinational S1 advance (no skid buffer).
    logic                   adv1;
    logic                   adv2;
    logic                   v1_q;
    logic                   v2_q;
    logic [AES_STATE_W-1:0] sr_d;
    logic [AES_STATE_W-1:0] mc_d;
    logic [AES_STATE_W-1:0] st1_d;
    logic [AES_STATE_W-1:0] st1_q;
    logic [AES_STATE_W-1:0] key1_q;
    logic [TAG_W-1:0]       tag1_q;
    logic [AES_STATE_W-1:0] out_state_d;
    logic [AES_STATE_W-1:0] out_state_q;
    logic [TAG_W-1:0]       out_tag_q;

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;

    // ShiftRows is a fixed byte permutation: out(r,c) = in(r,(c+r) mod 4).
    always_comb begin
        sr_d = '0;
        for (int c = 0; c < AES_NB; c++) begin
            for (int r = 0; r < AES_NB; r++) begin
`ifdef SMA_INV_EN
                sr_d[byte_msb(r, c) -: AES_BYTE_W] = in_inv
                    ? in_state[byte_msb(r, (c + AES_NB - r) % AES_NB) -: AES_BYTE_W]
                    : in_state[byte_msb(r, (c + r) % AES_NB) -: AES_BYTE_W];
`else
                sr_d[byte_msb(r, c) -: AES_BYTE_W] =
                    in_state[byte_msb(r, (c + r) % AES_NB) -: AES_BYTE_W];
`endif
            end
        end
    end

    for (genvar c = 0; c < AES_NB; c++) begin : g_mc
        mix_column u_mix_column (
            .col_i (sr_d[AES_STATE_W-1-32*c -: 32]),
`ifdef SMA_INV_EN
            .inv_i (in_inv),
`endif
            .col_o (mc_d[AES_STATE_W-1-32*c -: 32])
        );
    end

    assign st1_d       = in_last ? sr_d : mc_d;
    assign out_state_d = st1_q ^ key1_q;

    // Data registers load only with a valid beat, so idle-cycle inputs never reach S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            st1_q  <= '0;
            key1_q <= '0;
            tag1_q <= '0;
        end else if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                st1_q  <= st1_d;
                key1_q <= in_key;
                tag1_q <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q        <= 1'b0;
            out_state_q <= '0;
            out_tag_q   <= '0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                out_state_q <= out_state_d;
                out_tag_q   <= tag1_q;
            end
        end
    end

    assign out_valid = v2_q;
    assign out_state = out_state_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_shift_mix_ark.sv
// Bench for shift_mix_ark: known-answer table, latency, streaming, backpressure,
// random traffic against a matrix-form AES round model, and mid-flight reset.
module tb_shift_mix_ark;

    localparam int TAG_W = 4;
    localparam int W     = 128 + TAG_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [127:0]     in_state = '0;
    logic [127:0]     in_key = '0;
    logic             in_last = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
`ifdef SMA_INV_EN
    logic             in_inv = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [127:0]     out_state;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W:0]   hold_val;
    bit           hold_chk = 0;
    bit           saw_block = 0;
    bit           rnd_done = 0;
    int           out_cnt = 0;

    shift_mix_ark #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .in_tag    (in_tag),
`ifdef SMA_INV_EN
        .in_inv    (in_inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_tag   (out_tag)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        int acc;
        int x;
        acc = 0;
        x   = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
        end
        return acc[7:0];
    endfunction

    // State as a 4x4 byte matrix; the mix matrix is circulant, built from its first row.
    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                               input bit last, input bit inv);
        logic [7:0]   a[4][4];
        logic [7:0]   b[4][4];
        logic [7:0]   row0[4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv) begin
            row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
        end else begin
            row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                a[r][c] = s[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r][c] = inv ? a[r][(c - r + 4) % 4] : a[r][(c + r) % 4];
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (last) acc = b[r][c];
                else begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(row0[(j - r + 4) % 4], b[j][c]);
                end
                res[127-8*(4*c+r) -: 8] = acc ^ k[127-8*(4*c+r) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_chk = 0;
        end else begin
            if (hold_chk)
                check("stall_hold", 256'({out_valid, out_tag, out_state}), 256'(hold_val));
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got tag=%h state=%h expected no output", out_tag, out_state);
                end else begin
                    check("out_beat", 256'({out_tag, out_state}), 256'(exp_q.pop_front()));
                end
            end
            hold_chk = out_valid && !out_ready;
            hold_val = {out_valid, out_tag, out_state};
            if (out_valid && !out_ready && in_valid && !in_ready) saw_block = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [127:0] st, input logic [127:0] key, input bit last,
                        input logic [TAG_W-1:0] tag, input bit inv, input logic [127:0] exp,
                        output int waits);
        in_valid = 1'b1;
        in_state = st;
        in_key   = key;
        in_last  = last;
        in_tag   = tag;
`ifdef SMA_INV_EN
        in_inv   = inv;
`else
        if (inv) $display("note: inverse beat requested without inverse support");
`endif
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
        end else begin
            exp_q.push_back({tag, exp});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = rand128();
        in_key   = rand128();
        in_last  = 1'($urandom_range(0, 1));
        in_tag   = TAG_W'($urandom());
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending beats expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        logic [127:0] st;
        logic [127:0] key;
        bit           last;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int w;
        int cnt0;
        logic [127:0] s;
        logic [127:0] k;
        bit l;
        bit iv;

        vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
                    1'b0, 128'ha49c7ff2689f352b6b5bea43026a5049};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0,
                    1'b1, 128'h00050a0f04090e03080d02070c01060b};
        vecs[2] = '{128'hd400000000bf000000005d0000000030, 128'h0,
                    1'b0, 128'h046681e5000000000000000000000000};
        vecs[3] = '{128'h0, 128'hffffffffffffffffffffffffffffffff,
                    1'b0, 128'hffffffffffffffffffffffffffffffff};
        vecs[4] = '{128'h0, 128'h0123456789abcdeffedcba9876543210,
                    1'b1, 128'h0123456789abcdeffedcba9876543210};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_state", 256'(out_state), 256'(0));
        check("rst_out_tag", 256'(out_tag), 256'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 256'(in_ready), 256'(1));

        // Latency: one beat into an empty pipe shows up after exactly two edges
        in_valid = 1'b1;
        in_state = vecs[0].st;
        in_key   = vecs[0].key;
        in_last  = vecs[0].last;
        in_tag   = 4'h9;
        exp_q.push_back({4'h9, vecs[0].exp});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_edge1", 256'(out_valid), 256'(0));
        @(posedge clk);
        #1;
        check("lat_edge2", 256'(out_valid), 256'(1));
        drain();

        // Known-answer table
        for (int i = 0; i < 5; i++)
            send(vecs[i].st, vecs[i].key, vecs[i].last, TAG_W'(i), 1'b0, vecs[i].exp, w);
        drain();

        // 16-beat stream with the consumer always ready
        cnt0 = out_cnt;
        for (int t = 0; t < 16; t++) begin
            s = rand128();
            k = rand128();
            l = 1'($urandom_range(0, 1));
            send(s, k, l, TAG_W'(t), 1'b0, ref_round(s, k, l, 1'b0), w);
            check("stream_in_ready", 256'(w), 256'(0));
        end
        check("stream_no_bubble", 256'(out_cnt - cnt0), 256'(14));
        drain();
        check("stream_count", 256'(out_cnt - cnt0), 256'(16));

        // Backpressure: consumer stalls 5 cycles mid-stream
        saw_block = 0;
        cnt0 = out_cnt;
        fork
            begin
                for (int t = 0; t < 10; t++) begin
                    s = rand128();
                    k = rand128();
                    l = 1'($urandom_range(0, 1));
                    send(s, k, l, TAG_W'(t), 1'b0, ref_round(s, k, l, 1'b0), w);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_dropped", 256'(saw_block), 256'(1));
        check("bp_count", 256'(out_cnt - cnt0), 256'(10));

`ifdef SMA_INV_EN
        // Inverse round: column 046681e5 placed so InvShiftRows gathers it into column 0
        send(128'h04000000000000e50000810000660000, 128'h0, 1'b0, 4'h3, 1'b1,
             128'hd4bf5d30000000000000000000000000, w);
        drain();
`endif

        // Random traffic with random consumer readiness and idle gaps
        rnd_done = 0;
        fork
            begin
                for (int t = 0; t < 150; t++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    s = rand128();
                    k = rand128();
                    l = 1'($urandom_range(0, 1));
`ifdef SMA_INV_EN
                    iv = 1'($urandom_range(0, 1));
`else
                    iv = 1'b0;
`endif
                    send(s, k, l, TAG_W'($urandom()), iv, ref_round(s, k, l, iv), w);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(vecs[0].st, vecs[0].key, 1'b0, 4'h1, 1'b0, vecs[0].exp, w);
        send(vecs[1].st, vecs[1].key, 1'b1, 4'h2, 1'b0, vecs[1].exp, w);
        check("full_in_ready", 256'(in_ready), 256'(0));
        check("full_out_valid", 256'(out_valid), 256'(1));
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 256'(out_valid), 256'(0));
        check("arst_out_state", 256'(out_state), 256'(0));
        check("arst_in_ready", 256'(in_ready), 256'(1));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle", 256'(out_valid), 256'(0));
        send(vecs[2].st, vecs[2].key, vecs[2].last, 4'h5, 1'b0, vecs[2].exp, w);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
